// File: rtl/mem_stage_lsu_pkg.sv
// mem_stage_lsu_pkg: shared load/store encodings, writeback selects and LSU FSM states
package mem_stage_lsu_pkg;
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [1:0] RS_ALU = 2'b00;
   localparam logic [1:0] RS_MEM = 2'b01;
   localparam logic [1:0] RS_PC4 = 2'b10;
   typedef enum logic {IDLE, WAIT} lsuState_t;
endpackage

// File: rtl/lsu_data_memory.sv
// lsu_data_memory: word-organised data array with per-byte write enables and combinational read
module lsu_data_memory #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 1024
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [XLEN/8-1:0]        be,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [XLEN-1:0]          wd,
   output logic [XLEN-1:0]          rd
);
   logic [XLEN-1:0] mem [DEPTH];
   // write only the enabled byte lanes; contents are never reset
   always_ff @(posedge clk)
      for (int i = 0; i < XLEN/8; i++)
         if (we && be[i]) mem[addr][8*i +: 8] <= wd[8*i +: 8];
   assign rd = mem[addr];
endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory stage with byte/half/word loads and stores, optional wait states and M/W pipeline register
module mem_stage_lsu import mem_stage_lsu_pkg::*; #(
   parameter int XLEN    = 32,
   parameter int DEPTH   = 1024,
   parameter int MEM_LAT = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] ALUResultM,
   input  logic [XLEN-1:0] WriteDataM,
   input  logic [XLEN-1:0] PCPlus4M,
   input  logic [4:0]      RdM,
   input  logic            RegWriteM,
   input  logic            MemWriteM,
   input  logic            MemReadM,
   input  logic [2:0]      Funct3M,
   input  logic [1:0]      ResultSrcM,
   input  logic            FlushW,
   output logic            BusyM,
   output logic [XLEN-1:0] ALUResultW,
   output logic [XLEN-1:0] ReadDataW,
   output logic [XLEN-1:0] PCPlus4W,
   output logic [4:0]      RdW,
   output logic            RegWriteW,
   output logic [1:0]      ResultSrcW,
   output logic            MisalignW
);
   localparam int AW = $clog2(DEPTH);
   localparam int NB = XLEN / 8;
   localparam int CW = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
   lsuState_t       state, stateNext;
   logic [CW-1:0]   cnt, cntNext;
   logic [1:0]      off;
   logic            memAcc, misalign, aligned, lastWait, we;
   logic [NB-1:0]   be;
   logic [XLEN-1:0] wd, rd, rdShift, loadVal, readVal;
   assign off      = ALUResultM[1:0];
   assign memAcc   = MemReadM | MemWriteM;
   assign misalign = memAcc && ((Funct3M[1:0] == 2'b01 && off[0]) || (Funct3M[1:0] == 2'b10 && off != 2'b00));
   assign aligned  = memAcc && !misalign;
   assign lastWait = cnt == CW'(MEM_LAT - 1);
   assign be       = (Funct3M[1:0] == 2'b00 ? NB'(1) : Funct3M[1:0] == 2'b01 ? NB'(3) : {NB{1'b1}}) << off;
   assign wd       = WriteDataM << {off, 3'b000};
   assign we       = MemWriteM && !misalign && !BusyM && !rst;
   assign rdShift  = rd >> {off, 3'b000};
   assign readVal  = MemReadM && !misalign ? loadVal : XLEN'(0);
   lsu_data_memory #(.XLEN(XLEN), .DEPTH(DEPTH)) dmem (
      .clk(clk), .we(we), .be(be), .addr(ALUResultM[AW+1:2]), .wd(wd), .rd(rd)
   );
   // extract the addressed byte/halfword and extend it to XLEN
   always_comb begin
      loadVal = rd;
      case (Funct3M)
         F3_B:  loadVal = {{(XLEN-8){rdShift[7]}}, rdShift[7:0]};
         F3_H:  loadVal = {{(XLEN-16){rdShift[15]}}, rdShift[15:0]};
         F3_BU: loadVal = {{(XLEN-8){1'b0}}, rdShift[7:0]};
         F3_HU: loadVal = {{(XLEN-16){1'b0}}, rdShift[15:0]};
         default: loadVal = rd;
      endcase
   end
   // wait-state FSM register; reset aborts any access in flight
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= stateNext;
         cnt   <= cntNext;
      end
   // next state and stall: an access holds the stage for MEM_LAT cycles, completing on the last one
   always_comb begin
      stateNext = state;
      cntNext   = cnt;
      BusyM     = 1'b0;
      if (state == IDLE) begin
         BusyM     = aligned && (MEM_LAT > 0);
         stateNext = BusyM ? WAIT : IDLE;
         cntNext   = '0;
      end else begin
         BusyM     = !lastWait;
         stateNext = lastWait ? IDLE : WAIT;
         cntNext   = cnt + 1'b1;
      end
   end
   // W register: bubble on flush or stall, otherwise capture the completed instruction
   always_ff @(posedge clk or posedge rst)
      if (rst)
         {ALUResultW, ReadDataW, PCPlus4W, RdW, RegWriteW, ResultSrcW, MisalignW} <= '0;
      else if (FlushW || BusyM)
         {ALUResultW, ReadDataW, PCPlus4W, RdW, RegWriteW, ResultSrcW, MisalignW} <= '0;
      else
         {ALUResultW, ReadDataW, PCPlus4W, RdW, RegWriteW, ResultSrcW, MisalignW} <=
            {ALUResultM, readVal, PCPlus4M, RdM, RegWriteM && !misalign, ResultSrcM, misalign};
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed checks of a zero-latency and a two-wait-state LSU sharing one stimulus bus
module tb_mem_stage_lsu;
   import mem_stage_lsu_pkg::*;
   logic        clk = 1'b0, rst0, rst2;
   logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
   logic [4:0]  RdM;
   logic        RegWriteM, MemWriteM, MemReadM, FlushW;
   logic [2:0]  Funct3M;
   logic [1:0]  ResultSrcM;
   logic        BusyM0, RegWriteW0, MisalignW0, BusyM2, RegWriteW2, MisalignW2;
   logic [31:0] ALUResultW0, ReadDataW0, PCPlus4W0, ALUResultW2, ReadDataW2, PCPlus4W2;
   logic [4:0]  RdW0, RdW2;
   logic [1:0]  ResultSrcW0, ResultSrcW2;
   int nChecks = 0, nErrors = 0;

   mem_stage_lsu #(.MEM_LAT(0)) dut0 (
      .clk(clk), .rst(rst0), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
      .RdM(RdM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemReadM(MemReadM), .Funct3M(Funct3M),
      .ResultSrcM(ResultSrcM), .FlushW(FlushW), .BusyM(BusyM0), .ALUResultW(ALUResultW0),
      .ReadDataW(ReadDataW0), .PCPlus4W(PCPlus4W0), .RdW(RdW0), .RegWriteW(RegWriteW0),
      .ResultSrcW(ResultSrcW0), .MisalignW(MisalignW0));

   mem_stage_lsu #(.MEM_LAT(2)) dut2 (
      .clk(clk), .rst(rst2), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
      .RdM(RdM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemReadM(MemReadM), .Funct3M(Funct3M),
      .ResultSrcM(ResultSrcM), .FlushW(FlushW), .BusyM(BusyM2), .ALUResultW(ALUResultW2),
      .ReadDataW(ReadDataW2), .PCPlus4W(PCPlus4W2), .RdW(RdW2), .RegWriteW(RegWriteW2),
      .ResultSrcW(ResultSrcW2), .MisalignW(MisalignW2));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got !== exp) begin
         nErrors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic op(input logic w, input logic r, input logic rw, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd, input logic [1:0] rs);
      MemWriteM = w; MemReadM = r; RegWriteM = rw; Funct3M = f3;
      ALUResultM = a; WriteDataM = d; RdM = rd; ResultSrcM = rs; FlushW = 1'b0;
      #1;
   endtask

   task automatic st(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
      op(1'b1, 1'b0, 1'b0, f3, a, d, 5'd0, RS_ALU);
      tick;
   endtask

   task automatic ld(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] exp);
      op(1'b0, 1'b1, 1'b1, f3, a, 32'h0, 5'd3, RS_MEM);
      tick;
      chk(tag, ReadDataW0, exp);
   endtask

   initial begin
      rst0 = 1'b1; rst2 = 1'b1; PCPlus4M = 32'h104;
      op(1'b0, 1'b0, 1'b0, F3_W, 32'h0, 32'h0, 5'd0, RS_ALU);
      chk("reset regwrite0", RegWriteW0, 0);
      chk("reset alu0", ALUResultW0, 0);
      chk("reset rd2", RdW2, 0);
      tick;
      rst0 = 1'b0;
      op(1'b1, 1'b0, 1'b0, F3_W, 32'h10, 32'hDEADBEEF, 5'd0, RS_ALU);
      chk("sw busy lat0", BusyM0, 0);
      tick;
      op(1'b0, 1'b1, 1'b1, F3_W, 32'h10, 32'h0, 5'd5, RS_MEM);
      chk("lw busy lat0", BusyM0, 0);
      tick;
      chk("lw data", ReadDataW0, 32'hDEADBEEF);
      chk("lw rd", RdW0, 5);
      chk("lw regwrite", RegWriteW0, 1);
      chk("lw resultsrc", ResultSrcW0, RS_MEM);
      st(F3_W, 32'h10, 32'h0);
      st(F3_B, 32'h13, 32'h80);
      ld("lb", F3_B, 32'h13, 32'hFFFFFF80);
      ld("lbu", F3_BU, 32'h13, 32'h00000080);
      ld("lw after sb", F3_W, 32'h10, 32'h80000000);
      op(1'b0, 1'b1, 1'b1, F3_H, 32'h11, 32'h0, 5'd4, RS_MEM);
      tick;
      chk("lh misalign flag", MisalignW0, 1);
      chk("lh misalign regwrite", RegWriteW0, 0);
      chk("lh misalign data", ReadDataW0, 0);
      st(F3_W, 32'h12, 32'h12345678);
      chk("sw misalign flag", MisalignW0, 1);
      ld("sw misalign no write", F3_W, 32'h10, 32'h80000000);
      ld("lh upper", F3_H, 32'h12, 32'hFFFF8000);
      ld("lhu upper", F3_HU, 32'h12, 32'h00008000);
      st(F3_H, 32'h10, 32'h0000BEEF);
      ld("lw after sh", F3_W, 32'h10, 32'h8000BEEF);
      ld("lb byte0", F3_B, 32'h10, 32'hFFFFFFEF);
      ld("lbu byte1", F3_BU, 32'h11, 32'h000000BE);
      ld("alias read", F3_W, 32'h1010, 32'h8000BEEF);
      st(F3_W, 32'h1014, 32'hCAFEF00D);
      ld("alias write", F3_W, 32'h14, 32'hCAFEF00D);
      op(1'b0, 1'b1, 1'b1, F3_W, 32'h10, 32'h0, 5'd6, RS_MEM);
      FlushW = 1'b1;
      tick;
      chk("flush rd", RdW0, 0);
      chk("flush regwrite", RegWriteW0, 0);
      chk("flush data", ReadDataW0, 0);
      op(1'b1, 1'b0, 1'b0, F3_W, 32'h18, 32'h11112222, 5'd0, RS_ALU);
      FlushW = 1'b1;
      tick;
      ld("flush keeps store", F3_W, 32'h18, 32'h11112222);
      op(1'b0, 1'b0, 1'b1, F3_W, 32'h55, 32'h0, 5'd7, RS_ALU);
      tick;
      chk("alu result", ALUResultW0, 32'h55);
      chk("alu readdata", ReadDataW0, 0);
      chk("alu rd", RdW0, 7);
      chk("alu regwrite", RegWriteW0, 1);
      chk("alu pcplus4", PCPlus4W0, 32'h104);
      rst0 = 1'b1;
      #1;
      chk("async reset alu", ALUResultW0, 0);
      chk("async reset regwrite", RegWriteW0, 0);
      tick;
      rst0 = 1'b0;
      rst2 = 1'b0;
      op(1'b1, 1'b0, 1'b0, F3_W, 32'h20, 32'hA5A5A5A5, 5'd0, RS_ALU);
      chk("lat2 sw busy idle", BusyM2, 1);
      tick;
      chk("lat2 sw busy wait0", BusyM2, 1);
      tick;
      chk("lat2 sw busy final", BusyM2, 0);
      tick;
      op(1'b0, 1'b1, 1'b1, F3_W, 32'h20, 32'h0, 5'd9, RS_MEM);
      chk("lat2 lw busy idle", BusyM2, 1);
      tick;
      chk("lat2 bubble1 rd", RdW2, 0);
      chk("lat2 bubble1 regwrite", RegWriteW2, 0);
      chk("lat2 lw busy wait0", BusyM2, 1);
      tick;
      chk("lat2 bubble2 rd", RdW2, 0);
      chk("lat2 lw busy final", BusyM2, 0);
      tick;
      chk("lat2 lw data", ReadDataW2, 32'hA5A5A5A5);
      chk("lat2 lw rd", RdW2, 9);
      chk("lat2 lw regwrite", RegWriteW2, 1);
      op(1'b1, 1'b0, 1'b0, F3_W, 32'h20, 32'h5A5A5A5A, 5'd0, RS_ALU);
      tick;
      rst2 = 1'b1;
      #1;
      chk("rst in wait busy follows", BusyM2, 1);
      chk("rst in wait data", ReadDataW2, 0);
      op(1'b0, 1'b0, 1'b0, F3_W, 32'h0, 32'h0, 5'd0, RS_ALU);
      chk("rst in wait idle", BusyM2, 0);
      tick;
      rst2 = 1'b0;
      op(1'b0, 1'b0, 1'b0, F3_W, 32'h0, 32'h0, 5'd0, RS_ALU);
      chk("after rst not busy", BusyM2, 0);
      op(1'b0, 1'b1, 1'b1, F3_W, 32'h20, 32'h0, 5'd9, RS_MEM);
      tick;
      tick;
      tick;
      chk("rst aborted store", ReadDataW2, 32'hA5A5A5A5);
      op(1'b0, 1'b1, 1'b1, F3_W, 32'h22, 32'h0, 5'd9, RS_MEM);
      chk("lat2 misalign no wait", BusyM2, 0);
      tick;
      chk("lat2 misalign flag", MisalignW2, 1);
      chk("lat2 misalign regwrite", RegWriteW2, 0);
      $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
      $finish;
   end
endmodule
